// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester Memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_READ_LATENCY = 0;

  // Requester indices: instruction fetch port and load/store port.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // Sequencer states; every access walks IDLE -> ACCESS -> (WAIT ->) DONE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_idx_o,
  output logic       any_req_o
);

  // Pick the winner; with no request the index is don't-care and parked on the fetch port.
  always_comb begin
    gnt_idx_o = REQ_FETCH;
    any_req_o = |req_i;
    case (req_i)
      2'b10:   gnt_idx_o = REQ_DATA;
      2'b11:   gnt_idx_o = ~last_gnt_i;
      default: gnt_idx_o = REQ_FETCH;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch (0) and load/store (1) accesses onto one single-port Memory, round-robin on ties.
// Latency: request seen in cycle N -> done in N+2 (write) or N+2+READ_LATENCY (read); one access per 3+READ_LATENCY cycles.
// Backpressure: requesters hold req/we/addr/wdata until their done pulse; req is ignored while busy and in DONE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] Address,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] ReadData,
  output logic              busy
);

  // Wait counter only has to hold READ_LATENCY-1.
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (READ_LATENCY > 0) ? CNT_W'(READ_LATENCY - 1) : '0;

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt_idx;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              capture;
  logic              finish;

  rr_arb2 u_rr (
    .req_i      ({req1, req0}),
    .last_gnt_i (last_gnt_q),
    .gnt_idx_o  (gnt_idx),
    .any_req_o  (any_req)
  );

  assign sel_we    = (gnt_idx == REQ_DATA) ? we1    : we0;
  assign sel_addr  = (gnt_idx == REQ_DATA) ? addr1  : addr0;
  assign sel_wdata = (gnt_idx == REQ_DATA) ? wdata1 : wdata0;

  // Next-state logic: pick in IDLE, drive Memory from registers, pulse done on the way into DONE.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    done_d     = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    capture    = 1'b0;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d    = gnt_idx;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          mem_wr_d = sel_we;
          mem_rd_d = ~sel_we;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_wr_q) begin
          finish = 1'b1;
        end else if (READ_LATENCY == 0) begin
          capture = 1'b1;
          finish  = 1'b1;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        // Requests are deliberately not sampled here: the finishing requester still has req high.
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (gnt_q == REQ_DATA) rdata1_d = ReadData;
      else                   rdata0_d = ReadData;
    end

    if (finish) begin
      mem_rd_d      = 1'b0;
      mem_wr_d      = 1'b0;
      done_d[gnt_q] = 1'b1;
      state_d       = DONE;
    end
  end

  // State and output registers; a reset mid-access simply abandons it with no done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= REQ_FETCH;
      last_gnt_q <= REQ_DATA;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      done_q     <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      done_q     <= done_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign Address   = addr_q;
  assign MemRead   = mem_rd_q;
  assign MemWrite  = mem_wr_q;
  assign writeData = wdata_q;
  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (READ_LATENCY 0 and 2), each with a behavioural Memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    int          k;
    int          p;
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
  } vec_t;

  logic          clock;
  logic          reset;
  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          done  [2][2];
  logic [DW-1:0] rdata [2][2];
  logic [AW-1:0] Address   [2];
  logic          MemRead   [2];
  logic          MemWrite  [2];
  logic [DW-1:0] writeData [2];
  logic [DW-1:0] ReadData  [2];
  logic          busy      [2];

  logic [DW-1:0] mem [2][256];
  int            rd_run [2];
  logic          pl_vld;
  int            pl_k;
  logic [7:0]    pl_a;
  logic [31:0]   pl_d;

  logic [DW-1:0] exp_rd [2][2];
  int checks = 0;
  int errors = 0;
  vec_t tbl [8];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(0)) dut0 (
    .clock(clock), .reset(reset),
    .req0(req[0][0]), .we0(we[0][0]), .addr0(addr[0][0]), .wdata0(wdata[0][0]),
    .done0(done[0][0]), .rdata0(rdata[0][0]),
    .req1(req[0][1]), .we1(we[0][1]), .addr1(addr[0][1]), .wdata1(wdata[0][1]),
    .done1(done[0][1]), .rdata1(rdata[0][1]),
    .Address(Address[0]), .MemRead(MemRead[0]), .MemWrite(MemWrite[0]),
    .writeData(writeData[0]), .ReadData(ReadData[0]), .busy(busy[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset(reset),
    .req0(req[1][0]), .we0(we[1][0]), .addr0(addr[1][0]), .wdata0(wdata[1][0]),
    .done0(done[1][0]), .rdata0(rdata[1][0]),
    .req1(req[1][1]), .we1(we[1][1]), .addr1(addr[1][1]), .wdata1(wdata[1][1]),
    .done1(done[1][1]), .rdata1(rdata[1][1]),
    .Address(Address[1]), .MemRead(MemRead[1]), .MemWrite(MemWrite[1]),
    .writeData(writeData[1]), .ReadData(ReadData[1]), .busy(busy[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int rlat(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // Memory: writes on the edge closing a MemWrite cycle; read data only valid READ_LATENCY cycles into MemRead.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (MemWrite[k]) mem[k][Address[k]] <= writeData[k];
      rd_run[k] <= MemRead[k] ? rd_run[k] + 1 : 0;
    end
    if (pl_vld) mem[pl_k][pl_a] <= pl_d;
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      ReadData[k] = (MemRead[k] && rd_run[k] == rlat(k)) ? mem[k][Address[k]] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic preload(input int k, input logic [7:0] a, input logic [31:0] d);
    pl_k = k; pl_a = a; pl_d = d; pl_vld = 1'b1;
    @(negedge clock);
    pl_vld = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst MemRead", 32'(MemRead[k]), 0);
      chk("rst MemWrite", 32'(MemWrite[k]), 0);
      chk("rst Address", 32'(Address[k]), 0);
      chk("rst writeData", writeData[k], 0);
      chk("rst busy", 32'(busy[k]), 0);
      for (int p = 0; p < 2; p++) begin
        chk("rst done", 32'(done[k][p]), 0);
        chk("rst rdata", rdata[k][p], 0);
        exp_rd[k][p] = '0;
      end
    end
    reset = 1'b0;
  endtask

  // Simultaneous requests right after reset: fetch read first, load/store write second.
  task automatic tie_seq(input int it);
    logic [31:0] wd;
    wd = 32'hA + 32'(it);
    req[0][0] = 1; we[0][0] = 0; addr[0][0] = 8'h18;
    req[0][1] = 1; we[0][1] = 1; addr[0][1] = 8'h1C; wdata[0][1] = wd;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clock);
      chk("tie done0", 32'(done[0][0]), 32'(t == 2));
      chk("tie done1", 32'(done[0][1]), 32'(t == 5));
      chk("tie MemRead", 32'(MemRead[0]), 32'(t == 1));
      chk("tie MemWrite", 32'(MemWrite[0]), 32'(t == 4));
      chk("tie busy", 32'(busy[0]), 32'(t != 3));
      if (t == 1) chk("tie Address rd", 32'(Address[0]), 32'h18);
      if (t == 4) begin
        chk("tie Address wr", 32'(Address[0]), 32'h1C);
        chk("tie writeData", writeData[0], wd);
      end
      if (t == 2) begin exp_rd[0][0] = 32'h7; req[0][0] = 0; end
      if (t == 5) begin chk("tie mem 1C", mem[0][8'h1C], wd); req[0][1] = 0; end
      chk("tie rdata0", rdata[0][0], exp_rd[0][0]);
      chk("tie rdata1", rdata[0][1], exp_rd[0][1]);
    end
    @(negedge clock);
    chk("tie idle busy", 32'(busy[0]), 0);
  endtask

  task automatic single(input vec_t v);
    int lat;
    int o;
    o   = 1 - v.p;
    lat = v.w ? 0 : rlat(v.k);
    we[v.k][v.p] = v.w; addr[v.k][v.p] = v.a; wdata[v.k][v.p] = v.d; req[v.k][v.p] = 1;
    for (int t = 1; t <= lat + 2; t++) begin
      @(negedge clock);
      chk("vec MemWrite", 32'(MemWrite[v.k]), 32'(v.w && t == 1));
      chk("vec MemRead", 32'(MemRead[v.k]), 32'(!v.w && t <= lat + 1));
      chk("vec busy", 32'(busy[v.k]), 1);
      if (t <= lat + 1) chk("vec Address", 32'(Address[v.k]), 32'(v.a));
      if (v.w && t == 1) chk("vec writeData", writeData[v.k], v.d);
      chk("vec done own", 32'(done[v.k][v.p]), 32'(t == lat + 2));
      chk("vec done other", 32'(done[v.k][o]), 0);
      if (t == lat + 2) begin
        if (!v.w) exp_rd[v.k][v.p] = v.rd;
        else chk("vec mem write", mem[v.k][v.a], v.d);
        req[v.k][v.p] = 0;
      end
      chk("vec rdata own", rdata[v.k][v.p], exp_rd[v.k][v.p]);
      chk("vec rdata other", rdata[v.k][o], exp_rd[v.k][o]);
    end
    @(negedge clock);
    chk("vec idle busy", 32'(busy[v.k]), 0);
    chk("vec idle done", 32'(done[v.k][v.p]), 0);
  endtask

  task automatic reset_in_wait();
    req[1][0] = 1; we[1][0] = 0; addr[1][0] = 8'h0C;
    @(negedge clock);
    chk("rw MemRead access", 32'(MemRead[1]), 1);
    @(negedge clock);
    chk("rw MemRead wait", 32'(MemRead[1]), 1);
    chk("rw busy wait", 32'(busy[1]), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("rw MemRead after", 32'(MemRead[1]), 0);
    chk("rw busy after", 32'(busy[1]), 0);
    chk("rw done0 after", 32'(done[1][0]), 0);
    chk("rw rdata0 after", rdata[1][0], 0);
    reset = 1'b0; req[1][0] = 0;
    for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) exp_rd[k][p] = '0;
    repeat (3) begin
      @(negedge clock);
      chk("rw no done", 32'(done[1][0]), 0);
      chk("rw idle", 32'(busy[1]), 0);
    end
    single('{k: 1, p: 1, w: 1'b0, a: 8'h0C, d: 32'h0, rd: 32'h9});
  endtask

  // Random traffic against a cycle-level transaction model of the arbitration rules.
  task automatic random_run(input int k, input int n);
    int          last, busy_from, busy_to, g;
    int          exp_done [2];
    bit          granted [2], pend [2], tr_we [2], de;
    logic [7:0]  tr_a [2];
    logic [31:0] tr_d [2], tr_rd [2];
    logic [31:0] ref_mem [256];
    do_reset();
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[k][a];
    last = 1; busy_from = 0; busy_to = -1;
    for (int p = 0; p < 2; p++) begin
      granted[p] = 0; pend[p] = 0; exp_done[p] = -1;
    end
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < 2; p++) begin
        de = granted[p] && (c == exp_done[p]);
        chk("rnd done", 32'(done[k][p]), 32'(de));
        if (de) begin
          granted[p] = 0; pend[p] = 0; req[k][p] = 0;
          if (tr_we[p]) chk("rnd mem write", mem[k][tr_a[p]], tr_d[p]);
          else exp_rd[k][p] = tr_rd[p];
        end
        chk("rnd rdata", rdata[k][p], exp_rd[k][p]);
      end
      chk("rnd busy", 32'(busy[k]), 32'(c >= busy_from && c <= busy_to));
      chk("rnd rd/wr exclusive", 32'(MemRead[k] && MemWrite[k]), 0);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[p] = 1; req[k][p] = 1;
            we[k][p] = 1'($urandom_range(0, 1));
            addr[k][p] = 8'h80 + 8'(4 * $urandom_range(0, 7));
            wdata[k][p] = $urandom;
          end
        end else if (granted[p] && $urandom_range(0, 3) == 0) begin
          req[k][p] = 0; we[k][p] = ~we[k][p]; addr[k][p] = ~addr[k][p]; wdata[k][p] = $urandom;
        end
      end
      if (c > busy_to && (req[k][0] || req[k][1])) begin
        if (req[k][0] && req[k][1]) g = 1 - last;
        else g = req[k][1] ? 1 : 0;
        granted[g] = 1;
        exp_done[g] = c + 2 + (we[k][g] ? 0 : rlat(k));
        tr_we[g] = we[k][g]; tr_a[g] = addr[k][g]; tr_d[g] = wdata[k][g];
        if (we[k][g]) ref_mem[addr[k][g]] = wdata[k][g];
        else tr_rd[g] = ref_mem[addr[k][g]];
        last = g; busy_from = c + 1; busy_to = exp_done[g];
      end
      @(negedge clock);
    end
    for (int p = 0; p < 2; p++) req[k][p] = 0;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    pl_vld = 1'b0; pl_k = 0; pl_a = '0; pl_d = '0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 0; we[k][p] = 0; addr[k][p] = '0; wdata[k][p] = '0; exp_rd[k][p] = '0;
      end
    tbl[0] = '{k: 0, p: 0, w: 1'b1, a: 8'h04, d: 32'h2,    rd: 32'h0};
    tbl[1] = '{k: 0, p: 1, w: 1'b0, a: 8'h04, d: 32'h0,    rd: 32'h2};
    tbl[2] = '{k: 0, p: 0, w: 1'b0, a: 8'h04, d: 32'h0,    rd: 32'h2};
    tbl[3] = '{k: 0, p: 1, w: 1'b1, a: 8'h05, d: 32'h123,  rd: 32'h0};
    tbl[4] = '{k: 0, p: 0, w: 1'b0, a: 8'h05, d: 32'h0,    rd: 32'h123};
    tbl[5] = '{k: 1, p: 1, w: 1'b1, a: 8'h10, d: 32'h55AA, rd: 32'h0};
    tbl[6] = '{k: 1, p: 0, w: 1'b0, a: 8'h0C, d: 32'h0,    rd: 32'h9};
    tbl[7] = '{k: 1, p: 1, w: 1'b0, a: 8'h10, d: 32'h0,    rd: 32'h55AA};
    @(negedge clock);
    preload(0, 8'h18, 32'h7);
    preload(1, 8'h0C, 32'h9);
    do_reset();
    tie_seq(0);
    tie_seq(1);
    for (int i = 0; i < 8; i++) single(tbl[i]);
    reset_in_wait();
    random_run(0, 1500);
    random_run(1, 1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port word Memory (clock, Address, MemRead/ReadData, MemWrite/writeData).
- Sits between the CPU's fetch port (requester 0) and load/store port (requester 1) and the one Memory instance.
- Serialises accesses with round-robin fairness and a req/done handshake.
- Drives all Memory control from registers, so Memory sees clean, single-source signals.

Parameters:
- ADDR_W, 8, Memory address width (byte address, passed through unchanged).
- DATA_W, 32, data width.
- READ_LATENCY, 0, extra cycles after the MemRead cycle before ReadData is valid (0 = valid in the same cycle).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held with we0/addr0/wdata0 stable until done0.
- we0  in  1  1 = write, 0 = read.
- addr0  in  ADDR_W  access address.
- wdata0  in  DATA_W  write data.
- done0  out  1  one-cycle completion pulse.
- rdata0  out  DATA_W  read result; valid when done0=1 for a read, otherwise holds its last value.
- req1, we1, addr1, wdata1, done1, rdata1: same as above, for requester 1.
- Address  out  ADDR_W  to Memory.
- MemRead  out  1  to Memory.
- MemWrite  out  1  to Memory.
- writeData  out  DATA_W  to Memory.
- ReadData  in  DATA_W  from Memory.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: Address=0, MemRead=0, MemWrite=0, writeData=0, done0/1=0, rdata0/1=0, state=IDLE, last_gnt=1 (so requester 0 wins the first tie).
- States and transitions:
  - IDLE: req sampled at posedge.
    - No req: stay in IDLE.
    - Any req: latch winner, its we/addr/wdata go into the Memory output registers, go to ACCESS.
  - ACCESS (1 cycle): exactly one of MemRead or MemWrite is 1, with Address/writeData from the winner.
    - Write: Memory writes at the closing edge; go to DONE.
    - Read with READ_LATENCY=0: capture ReadData into rdata[winner] at the closing edge; go to DONE.
    - Read with READ_LATENCY>0: load the wait counter with READ_LATENCY-1; go to WAIT.
  - WAIT: MemRead and Address held.
    - Counter decrements each cycle.
    - At counter==0: capture ReadData; go to DONE.
  - DONE (1 cycle): MemRead=MemWrite=0, done[winner]=1, last_gnt=winner.
    - Req is NOT sampled in this cycle (the requester's req is still high); next state is IDLE.
- Latency, from the first IDLE cycle with req high (cycle N):
  - write: done in cycle N+2.
  - read: done in cycle N+2+READ_LATENCY.
  - Back-to-back throughput: one access per 3+READ_LATENCY cycles.
- Arbitration:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester != last_gnt.
  - A requester that keeps req high across DONE re-arbitrates as a new access.
- Writes do not modify rdata of either port. The non-granted port's done stays 0 and its rdata is unchanged.
- Req deasserted mid-transaction is ignored; the access completes and done still pulses.
- Reset mid-operation:
  - All registers take their reset values at that edge.
  - A MemWrite already high at the reset edge still writes (Memory samples the same edge).
  - No done is issued for the aborted access.
- Address/data are passed through without alignment checks.
- MemRead and MemWrite are never both 1.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, WAIT, DONE};
  - requester index constants REQ_FETCH=0, REQ_DATA=1;
  - default width constants.
- Sub-module rr_arb2: combinational 2-way round-robin pick (req[1:0], last_gnt -> gnt_idx, any_req).

Test Plan:
- Reset held 2 cycles -> all outputs 0, busy=0; first tie after release goes to requester 0.
- Requester 0 writes addr 0x04, data 0x00000002, req at cycle N:
  - MemWrite=1, Address=0x04, writeData=0x2 exactly during N+1;
  - done0=1 only in N+2;
  - Memory[0x04]=2.
- READ_LATENCY=0, requester 1 reads 0x04 -> MemRead=1 only in N+1; done1 and rdata1=0x00000002 in N+2; rdata0 unchanged.
- Both req at N (req0 read 0x18 pre-loaded with 0x7, req1 write 0x1C=0xA), both held until their done:
  - req0 served first: done0 in N+2, rdata0=0x7;
  - req1 served second: done1 in N+5, Memory[0x1C]=0xA;
  - repeating the tie grants requester 0 first again (alternation).
- READ_LATENCY=2, read 0x0C (=0x9) -> MemRead high N+1..N+3, done and rdata=0x9 in N+4.
- READ_LATENCY=2, reset asserted during WAIT -> next cycle MemRead=0, busy=0, no done pulse; a subsequent req1 read completes normally in N+4.
